// File: rtl/bitbrick_pkg.sv
// -----------------------------------------------------------------------------
// bitbrick_pkg
// Shared definitions for the bit-brick sequencer slice.
//   - Lane/plane geometry: 16 lanes of 8b operands, cut into 2b slices.
//   - prec_e    : operand precision codes. 11 is handled the same as 8b.
//   - state_e   : sequencer FSM states.
//   - sliceCount: number of 2b slices for a precision code (1, 2 or 4).
// -----------------------------------------------------------------------------
package bitbrick_pkg;

    localparam int LANES   = 16;
    localparam int LANE_W  = 8;
    localparam int SLICE_W = 2;
    localparam int VEC_W   = LANES * LANE_W;
    localparam int PLANE_W = LANES * SLICE_W;

    typedef enum logic [1:0] {
        PREC_2B     = 2'b00,
        PREC_4B     = 2'b01,
        PREC_8B     = 2'b10,
        PREC_8B_ALT = 2'b11
    } prec_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_e;

    function automatic logic [2:0] sliceCount(input logic [1:0] prec);
        case (prec_e'(prec))
            PREC_2B: sliceCount = 3'd1;
            PREC_4B: sliceCount = 3'd2;
            default: sliceCount = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/bitbrick_plane_slicer.sv
// -----------------------------------------------------------------------------
// bitbrick_plane_slicer
// Combinational extraction of one 2b slice plane from a 16-lane 8b vector.
// Ports:
//   i_vec   [127:0] : 16 lanes x 8b, lane n at bits [8n+7:8n]
//   i_k     [1:0]   : slice index, selects bits [2k+1:2k] of every lane
//   o_plane [31:0]  : lane n slice at bits [2n+1:2n]
// -----------------------------------------------------------------------------
module bitbrick_plane_slicer
    import bitbrick_pkg::*;
(
    input  logic [VEC_W-1:0]   i_vec,
    input  logic [1:0]         i_k,
    output logic [PLANE_W-1:0] o_plane
);

    always_comb begin
        o_plane = '0;
        for (int n = 0; n < LANES; n++) begin
            o_plane[n*SLICE_W +: SLICE_W] = i_vec[n*LANE_W + SLICE_W*int'(i_k) +: SLICE_W];
        end
    end

endmodule

// File: rtl/bitbrick_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bitbrick_seq_ctrl
// Sequences a 16-lane dot product through a 2b x 2b bit-brick PE. Each job
// issues one (activation slice i, weight slice j) pair per cycle, i outer and
// j inner, then accumulates the shifted PE sums into a signed result.
//
// Ports:
//   i_clk, i_rst                 : clock, asynchronous active-high reset
//   i_start                      : job request, only looked at in IDLE
//   i_a_prec, i_w_prec           : precision codes (00=2b, 01=4b, 1x=8b)
//   i_a_signed, i_w_signed       : operand signedness
//   i_act_vec, i_wgt_vec         : 16 lanes x 8b operand vectors
//   o_pe_act, o_pe_wgt           : current slice planes to the PE
//   o_pe_a_signed, o_pe_w_signed : slice carries the operand sign bit
//   o_pe_shift                   : 2*(i+j) weight of the current pair
//   i_pe_prod                    : registered PE lane sum (one-cycle latency)
//   o_busy, o_valid, o_result    : job status, done pulse, ACC_W signed result
//
// Configuration macro BITBRICK_SEQ_SKIP_EN: when defined, activation slices
// whose plane is all zero are skipped entirely.
// -----------------------------------------------------------------------------
module bitbrick_seq_ctrl
    import bitbrick_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [1:0]              i_a_prec,
    input  logic [1:0]              i_w_prec,
    input  logic                    i_a_signed,
    input  logic                    i_w_signed,
    input  logic [127:0]            i_act_vec,
    input  logic [127:0]            i_wgt_vec,
    output logic [31:0]             o_pe_act,
    output logic [31:0]             o_pe_wgt,
    output logic                    o_pe_a_signed,
    output logic                    o_pe_w_signed,
    output logic [3:0]              o_pe_shift,
    input  logic signed [8:0]       i_pe_prod,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] o_result
);

    state_e                  r_state;
    logic [VEC_W-1:0]        r_actVec;
    logic [VEC_W-1:0]        r_wgtVec;
    logic [2:0]              r_pa;
    logic [2:0]              r_pw;
    logic                    r_aSigned;
    logic                    r_wSigned;
    logic [1:0]              r_i;
    logic [1:0]              r_j;
    logic                    r_prodValid;
    logic [3:0]              r_shiftD;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_result;
    logic                    r_busy;
    logic                    r_valid;

    logic                    w_issue;
    logic [PLANE_W-1:0]      w_actPlane;
    logic [PLANE_W-1:0]      w_wgtPlane;
    logic [3:0]              w_shift;
    logic                    w_iLast;
    logic                    w_jLast;
    logic [1:0]              w_iNext;
    logic [1:0]              w_iFirst;
    logic                    w_startEmpty;
    logic signed [ACC_W-1:0] w_prodExt;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_accNext;

    bitbrick_plane_slicer u_actSlicer (
        .i_vec   (r_actVec),
        .i_k     (r_i),
        .o_plane (w_actPlane)
    );

    bitbrick_plane_slicer u_wgtSlicer (
        .i_vec   (r_wgtVec),
        .i_k     (r_j),
        .o_plane (w_wgtPlane)
    );

`ifdef BITBRICK_SEQ_SKIP_EN
    logic [3:0] r_actNz;
    logic [3:0] w_startNz;
    logic [2:0] w_firstIdx;
    logic [2:0] w_nextIdx;

    // Lowest set bit of mask at or above 'from'; 4 means none left.
    function automatic logic [2:0] firstSetFrom(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] idx;
        idx = 3'd4;
        for (int b = 3; b >= 0; b--) begin
            if (mask[b] && (3'(b) >= from)) idx = 3'(b);
        end
        return idx;
    endfunction

    // Nonzero map of the activation planes that belong to this precision.
    for (genvar k = 0; k < 4; k++) begin : g_nz
        logic [PLANE_W-1:0] w_plane;
        bitbrick_plane_slicer u_nzSlicer (
            .i_vec   (i_act_vec),
            .i_k     (2'(k)),
            .o_plane (w_plane)
        );
        assign w_startNz[k] = (|w_plane) && (3'(k) < sliceCount(i_a_prec));
    end

    assign w_firstIdx   = firstSetFrom(w_startNz, 3'd0);
    assign w_nextIdx    = firstSetFrom(r_actNz, {1'b0, r_i} + 3'd1);
    assign w_iFirst     = w_firstIdx[1:0];
    assign w_iNext      = w_nextIdx[1:0];
    assign w_iLast      = w_nextIdx[2];
    assign w_startEmpty = w_firstIdx[2];
`else
    assign w_iFirst     = 2'd0;
    assign w_iNext      = r_i + 2'd1;
    assign w_iLast      = ({1'b0, r_i} == r_pa - 3'd1);
    assign w_startEmpty = 1'b0;
`endif

    assign w_issue = (r_state == ST_ISSUE);
    assign w_jLast = ({1'b0, r_j} == r_pw - 3'd1);
    assign w_shift = {({1'b0, r_i} + {1'b0, r_j}), 1'b0};

    // The PE only sees a pair while ISSUE; everything reads as zero otherwise.
    assign o_pe_act      = w_issue ? w_actPlane : '0;
    assign o_pe_wgt      = w_issue ? w_wgtPlane : '0;
    assign o_pe_shift    = w_issue ? w_shift : 4'd0;
    assign o_pe_a_signed = w_issue && r_aSigned && ({1'b0, r_i} == r_pa - 3'd1);
    assign o_pe_w_signed = w_issue && r_wSigned && w_jLast;

    // i_pe_prod belongs to the pair issued last cycle, so it is weighted with
    // the shift captured one cycle ago and gated by the matching valid flag.
    assign w_prodExt = {{(ACC_W-9){i_pe_prod[8]}}, i_pe_prod};
    assign w_term    = r_prodValid ? (w_prodExt << r_shiftD) : '0;
    assign w_accNext = r_acc + w_term;

    assign o_busy   = r_busy;
    assign o_valid  = r_valid;
    assign o_result = r_result;

    // Sequencer FSM. The final product arrives during DRAIN and is folded
    // straight into o_result, giving a done pulse N+1 cycles after start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_actVec    <= '0;
            r_wgtVec    <= '0;
            r_pa        <= 3'd1;
            r_pw        <= 3'd1;
            r_aSigned   <= 1'b0;
            r_wSigned   <= 1'b0;
            r_i         <= 2'd0;
            r_j         <= 2'd0;
            r_prodValid <= 1'b0;
            r_shiftD    <= 4'd0;
            r_acc       <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
`ifdef BITBRICK_SEQ_SKIP_EN
            r_actNz     <= 4'd0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_prodValid <= w_issue;
            r_shiftD    <= o_pe_shift;
            r_acc       <= w_accNext;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_actVec  <= i_act_vec;
                        r_wgtVec  <= i_wgt_vec;
                        r_pa      <= sliceCount(i_a_prec);
                        r_pw      <= sliceCount(i_w_prec);
                        r_aSigned <= i_a_signed;
                        r_wSigned <= i_w_signed;
                        r_i       <= w_iFirst;
                        r_j       <= 2'd0;
                        r_acc     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= w_startEmpty ? ST_DRAIN : ST_ISSUE;
`ifdef BITBRICK_SEQ_SKIP_EN
                        r_actNz   <= w_startNz;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (w_jLast) begin
                        r_j <= 2'd0;
                        if (w_iLast) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_i <= w_iNext;
                        end
                    end else begin
                        r_j <= r_j + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    r_result <= w_accNext;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitbrick_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bitbrick_seq_ctrl
// Scoreboard bench for bitbrick_seq_ctrl. Jobs push their hand-computed result
// and done edge into a queue; a monitor pops an entry on every o_valid.
// A behavioural 2b x 2b PE with one-cycle latency closes the loop.
// -----------------------------------------------------------------------------
module tb_bitbrick_seq_ctrl;

    localparam int ACC_W = 24;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [1:0]              aPrec = 2'd0;
    logic [1:0]              wPrec = 2'd0;
    logic                    aSigned = 1'b0;
    logic                    wSigned = 1'b0;
    logic [127:0]            actVec = '0;
    logic [127:0]            wgtVec = '0;
    logic [31:0]             peAct;
    logic [31:0]             peWgt;
    logic                    peASigned;
    logic                    peWSigned;
    logic [3:0]              peShift;
    logic signed [8:0]       peProd;
    logic                    busy;
    logic                    valid;
    logic signed [ACC_W-1:0] result;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0] ap;
        logic [1:0] wp;
        logic       aSgn;
        logic       wSgn;
        logic [7:0] actByte;
        logic [7:0] wgtByte;
        logic       ramp;
        int         expResult;
        int         nPlain;
        int         nSkip;
    } vec_t;

    typedef struct {
        int    expResult;
        int    expEdge;
        string name;
    } sbEntry_t;

    vec_t     vecs[9];
    sbEntry_t sb[$];

    bitbrick_seq_ctrl #(.ACC_W(ACC_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_a_prec      (aPrec),
        .i_w_prec      (wPrec),
        .i_a_signed    (aSigned),
        .i_w_signed    (wSigned),
        .i_act_vec     (actVec),
        .i_wgt_vec     (wgtVec),
        .o_pe_act      (peAct),
        .o_pe_wgt      (peWgt),
        .o_pe_a_signed (peASigned),
        .o_pe_w_signed (peWSigned),
        .o_pe_shift    (peShift),
        .i_pe_prod     (peProd),
        .o_busy        (busy),
        .o_valid       (valid),
        .o_result      (result)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Count rising edges so the monitor can check the done-pulse edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Sum of 16 lane products of 2b slices; sign flag makes a slice -2..1.
    function automatic int peSum(logic [31:0] a, logic [31:0] w, logic aS, logic wS);
        int sum;
        int av;
        int wv;
        sum = 0;
        for (int n = 0; n < 16; n++) begin
            av = int'(a[2*n +: 2]);
            wv = int'(w[2*n +: 2]);
            if (aS && a[2*n+1]) av -= 4;
            if (wS && w[2*n+1]) wv -= 4;
            sum += av * wv;
        end
        return sum;
    endfunction

    // Behavioural PE: registered lane sum, reset together with the sequencer.
    always @(posedge clk or posedge rst) begin
        if (rst) peProd <= '0;
        else     peProd <= 9'(peSum(peAct, peWgt, peASigned, peWSigned));
    end

    function automatic logic [127:0] buildVec(logic [7:0] b, logic ramp);
        logic [127:0] v;
        for (int n = 0; n < 16; n++) v[8*n +: 8] = ramp ? 8'(n) : b;
        return v;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one job and, when push is set, record its expected response.
    task automatic applyStimulus(input int idx, input bit push);
        vec_t v;
        int   n;
        v = vecs[idx];
        @(negedge clk);
        aPrec   = v.ap;
        wPrec   = v.wp;
        aSigned = v.aSgn;
        wSigned = v.wSgn;
        actVec  = buildVec(v.actByte, v.ramp);
        wgtVec  = buildVec(v.wgtByte, 1'b0);
        start   = 1'b1;
`ifdef BITBRICK_SEQ_SKIP_EN
        n = v.nSkip;
`else
        n = v.nPlain;
`endif
        if (push) sb.push_back('{v.expResult, cyc + n + 2, $sformatf("job%0d", idx)});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int budget;
        budget = 60;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput({name, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: every o_valid must match the oldest outstanding job.
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpectedValid: o_valid=1 with result %0d, required no pulse", result);
                end else begin
                    sbEntry_t e;
                    e = sb.pop_front();
                    checkOutput({e.name, "_result"}, result, e.expResult);
                    checkOutput({e.name, "_edge"}, cyc, e.expEdge);
                end
            end
        end
    end

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Main directed sequence.
    initial begin
        vecs[0] = '{2'd0, 2'd0, 1'b0, 1'b0, 8'd3,   8'd3,   1'b0, 144,     1,  1};
        vecs[1] = '{2'd2, 2'd2, 1'b1, 1'b1, 8'h80,  8'h80,  1'b0, 262144,  16, 4};
        vecs[2] = '{2'd2, 2'd2, 1'b0, 1'b0, 8'hFF,  8'hFF,  1'b0, 1040400, 16, 16};
        vecs[3] = '{2'd1, 2'd2, 1'b1, 1'b0, 8'hF8,  8'd200, 1'b0, -25600,  8,  4};
        vecs[4] = '{2'd3, 2'd3, 1'b0, 1'b0, 8'd3,   8'd5,   1'b0, 240,     16, 4};
        vecs[5] = '{2'd0, 2'd0, 1'b1, 1'b1, 8'd2,   8'd3,   1'b0, 32,      1,  1};
        vecs[6] = '{2'd2, 2'd2, 1'b0, 1'b0, 8'd0,   8'h55,  1'b0, 0,       16, 0};
        vecs[7] = '{2'd1, 2'd1, 1'b0, 1'b0, 8'd0,   8'd3,   1'b1, 360,     4,  4};
        vecs[8] = '{2'd2, 2'd2, 1'b1, 1'b0, 8'hFF,  8'd1,   1'b0, -16,     16, 16};

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_peAct", peAct, 0);
        checkOutput("rst_peShift", peShift, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(i, 1'b1);
            waitDrain($sformatf("job%0d", i));
        end

        // Start pulsed while busy must be ignored.
        applyStimulus(7, 1'b1);
        applyStimulus(0, 1'b0);
        checkOutput("ignore_busy", busy, 1);
        waitDrain("ignore");
        repeat (20) @(negedge clk);

        // Reset in the 5th ISSUE cycle of an 8b job.
        applyStimulus(2, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_shift", peShift, 2);
        checkOutput("mid_peAct", peAct, 32'hFFFF_FFFF);
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        checkOutput("midRst_busy", busy, 0);
        checkOutput("midRst_valid", valid, 0);
        checkOutput("midRst_result", result, 0);
        checkOutput("midRst_peAct", peAct, 0);
        checkOutput("midRst_peShift", peShift, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(0, 1'b1);
        waitDrain("afterReset");

        // Second job accepted in the o_valid cycle of the first.
        applyStimulus(0, 1'b1);
        repeat (2) @(posedge clk);
        applyStimulus(3, 1'b1);
        waitDrain("backToBack");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
